// File: rtl/bomb_slot_engine.sv
// ---------------------------------------------------------------------------
// bomb_slot_engine
//
// Bomb bookkeeping for a 16x16 tile arena. A shared pool of SLOTS bomb slots
// is filled by per-player placement requests. Each live bomb counts down its
// fuse on the game tick. Bombs that sit under an incoming flame tile are
// detonated early, which gives chain reactions. Detonations leave the block
// one per cycle as a registered event stream for the wall/gadget/flame logic.
//
// Handshakes: put[p] is a one-cycle request that is sampled on every clock.
// put_ack[p] is the one-cycle answer on the following cycle. No ack means the
// request was rejected and dropped; the requester does not retry implicitly.
// det_valid is a one-cycle event strobe with no back-pressure. det_cor,
// det_len and det_owner are meaningful only while det_valid is high and are
// zero otherwise.
//
// Ports
//   CLOCK_50   in   system clock
//   reset      in   asynchronous, active-high reset
//   tick       in   game-tick enable, one-cycle pulse
//   put        in   placement request per player
//   cor        in   player tile {y,x}; player p at [8p+:8]
//   cap        in   per-player bomb capacity (0..7); player p at [3p+:3]
//   len        in   per-player flame length, latched at placement; [2p+:2]
//   flame      in   current flame tiles, indexed by tile coordinate
//   put_ack    out  placement accepted, one-cycle pulse
//   det_valid  out  detonation event strobe
//   det_cor    out  tile of the detonating bomb
//   det_len    out  flame length of the detonating bomb
//   det_owner  out  owning player index
//   bomb_map   out  1 = live bomb on that tile
//   live_cnt   out  live bombs per player; player p at [3p+:3]
// ---------------------------------------------------------------------------
module bomb_slot_engine #(
    parameter int NUM_PLAYERS = 2,
    parameter int SLOTS       = 8,
    parameter int FUSE_TICKS  = 90,
    parameter int FUSE_W      = 7
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     tick,
    input  logic [NUM_PLAYERS-1:0]   put,
    input  logic [8*NUM_PLAYERS-1:0] cor,
    input  logic [3*NUM_PLAYERS-1:0] cap,
    input  logic [2*NUM_PLAYERS-1:0] len,
    input  logic [255:0]             flame,
    output logic [NUM_PLAYERS-1:0]   put_ack,
    output logic                     det_valid,
    output logic [7:0]               det_cor,
    output logic [1:0]               det_len,
    output logic [1:0]               det_owner,
    output logic [255:0]             bomb_map,
    output logic [3*NUM_PLAYERS-1:0] live_cnt
);

    localparam int SLOT_W = $clog2(SLOTS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Slot table.
    logic [SLOTS-1:0]             valid_q, valid_d;
    logic [SLOTS-1:0]             pend_q, pend_d;
    logic [SLOTS-1:0][7:0]        cor_q, cor_d;
    logic [SLOTS-1:0][1:0]        owner_q, owner_d;
    logic [SLOTS-1:0][1:0]        len_q, len_d;
    logic [SLOTS-1:0][FUSE_W-1:0] fuse_q, fuse_d;

    // Emission FSM state. It is kept as a named register so that checkers can
    // observe it.
    state_t                       state_q, state_d;

    // Registered outputs.
    logic [NUM_PLAYERS-1:0]       put_ack_q, put_ack_d;
    logic                         det_valid_q, det_valid_d;
    logic [7:0]                   det_cor_q, det_cor_d;
    logic [1:0]                   det_len_q, det_len_d;
    logic [1:0]                   det_owner_q, det_owner_d;
    logic [255:0]                 bomb_map_q, bomb_map_d;
    logic [3*NUM_PLAYERS-1:0]     live_cnt_q, live_cnt_d;

    // Combinational scratch values.
    logic                         emit;
    logic [SLOT_W-1:0]            emit_idx;
    logic [SLOTS-1:0]             slot_used;
    logic                         slot_found;
    logic [SLOT_W-1:0]            free_idx;
    logic [7:0]                   req_cor;
    logic                         req_ok;
    logic                         dec;

    always_comb begin
        valid_d     = valid_q;
        pend_d      = pend_q;
        cor_d       = cor_q;
        owner_d     = owner_q;
        len_d       = len_q;
        fuse_d      = fuse_q;
        state_d     = state_q;
        put_ack_d   = '0;
        det_valid_d = 1'b0;
        det_cor_d   = '0;
        det_len_d   = '0;
        det_owner_d = '0;
        bomb_map_d  = bomb_map_q;
        live_cnt_d  = live_cnt_q;
        emit        = 1'b0;
        emit_idx    = '0;
        slot_used   = valid_q;
        slot_found  = 1'b0;
        free_idx    = '0;
        req_cor     = '0;
        req_ok      = 1'b0;
        dec         = 1'b0;

        // Fuse countdown and chain trigger. A pending slot is frozen and waits
        // for its emission turn. A flame hit marks the slot pending no matter
        // what the fuse holds.
        for (int s = 0; s < SLOTS; s++) begin
            if (valid_q[s] && !pend_q[s]) begin
                if (flame[cor_q[s]]) begin
                    pend_d[s] = 1'b1;
                end else if (tick) begin
                    fuse_d[s] = fuse_q[s] - FUSE_W'(1);
                    if (fuse_q[s] == FUSE_W'(1)) begin
                        pend_d[s] = 1'b1;
                    end
                end
            end
        end

        // While in EMIT, pick the lowest-index pending slot. The loop runs
        // downward so that the last match is the lowest index.
        if (state_q == ST_EMIT) begin
            for (int s = SLOTS - 1; s >= 0; s--) begin
                if (pend_q[s]) begin
                    emit     = 1'b1;
                    emit_idx = SLOT_W'(s);
                end
            end
        end

        if (emit) begin
            valid_d[emit_idx]              = 1'b0;
            pend_d[emit_idx]               = 1'b0;
            det_valid_d                    = 1'b1;
            det_cor_d                      = cor_q[emit_idx];
            det_len_d                      = len_q[emit_idx];
            det_owner_d                    = owner_q[emit_idx];
            bomb_map_d[cor_q[emit_idx]]    = 1'b0;
        end

        // Placement is served in player order. The free-slot search uses
        // valid_q, so a slot that is being emitted this cycle is not reused
        // until the next cycle. The tile test checks both bomb_map_q and
        // bomb_map_d:
        //   - bomb_map_q rejects the tile of the bomb detonating this cycle.
        //   - bomb_map_d rejects a tile already claimed by a lower-indexed
        //     player in this same cycle.
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            req_cor = cor[8*p +: 8];
            req_ok  = put[p]
                      && (live_cnt_q[3*p +: 3] < cap[3*p +: 3])
                      && !bomb_map_q[req_cor]
                      && !bomb_map_d[req_cor];
            slot_found = 1'b0;
            free_idx   = '0;
            for (int s = SLOTS - 1; s >= 0; s--) begin
                if (!slot_used[s]) begin
                    slot_found = 1'b1;
                    free_idx   = SLOT_W'(s);
                end
            end
            if (req_ok && slot_found) begin
                slot_used[free_idx] = 1'b1;
                valid_d[free_idx]   = 1'b1;
                pend_d[free_idx]    = 1'b0;
                cor_d[free_idx]     = req_cor;
                owner_d[free_idx]   = 2'(p);
                len_d[free_idx]     = len[2*p +: 2];
                fuse_d[free_idx]    = FUSE_W'(FUSE_TICKS);
                bomb_map_d[req_cor] = 1'b1;
                put_ack_d[p]        = 1'b1;
            end
        end

        // A player's count goes up only on an accepted put and down only on
        // its own emission. Both can happen in the same cycle, so the count
        // can neither wrap nor drift.
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            dec = emit && (det_owner_d == 2'(p));
            live_cnt_d[3*p +: 3] = live_cnt_q[3*p +: 3]
                                   + {2'b00, put_ack_d[p]}
                                   - {2'b00, dec};
        end

        // Stay in EMIT while anything is still pending after this cycle,
        // including slots that became pending just now.
        case (state_q)
            ST_IDLE: if (|pend_q) state_d = ST_EMIT;
            ST_EMIT: if (!(|pend_d)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            valid_q     <= '0;
            pend_q      <= '0;
            cor_q       <= '0;
            owner_q     <= '0;
            len_q       <= '0;
            fuse_q      <= '0;
            state_q     <= ST_IDLE;
            put_ack_q   <= '0;
            det_valid_q <= 1'b0;
            det_cor_q   <= '0;
            det_len_q   <= '0;
            det_owner_q <= '0;
            bomb_map_q  <= '0;
            live_cnt_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            pend_q      <= pend_d;
            cor_q       <= cor_d;
            owner_q     <= owner_d;
            len_q       <= len_d;
            fuse_q      <= fuse_d;
            state_q     <= state_d;
            put_ack_q   <= put_ack_d;
            det_valid_q <= det_valid_d;
            det_cor_q   <= det_cor_d;
            det_len_q   <= det_len_d;
            det_owner_q <= det_owner_d;
            bomb_map_q  <= bomb_map_d;
            live_cnt_q  <= live_cnt_d;
        end
    end

    assign put_ack   = put_ack_q;
    assign det_valid = det_valid_q;
    assign det_cor   = det_cor_q;
    assign det_len   = det_len_q;
    assign det_owner = det_owner_q;
    assign bomb_map  = bomb_map_q;
    assign live_cnt  = live_cnt_q;

endmodule

// File: tb/tb_bomb_slot_engine.sv
// ---------------------------------------------------------------------------
// tb_bomb_slot_engine
//
// Directed bench for bomb_slot_engine with the default parameters:
// 2 players, 8 slots, fuse of 90 ticks. Inputs are driven 1 time unit after
// each rising edge. Outputs are sampled at that same point, so every check
// sees the result of the edge that just happened.
// ---------------------------------------------------------------------------
module tb_bomb_slot_engine;

    localparam int NP = 2;
    localparam int SL = 8;
    localparam int FT = 90;
    localparam int FW = 7;

    // Clock and reset.
    logic              CLOCK_50 = 1'b0;
    logic              reset    = 1'b1;

    // DUT inputs.
    logic              tick     = 1'b0;
    logic [NP-1:0]     put      = '0;
    logic [8*NP-1:0]   cor      = '0;
    logic [3*NP-1:0]   cap      = '0;
    logic [2*NP-1:0]   len      = '0;
    logic [255:0]      flame    = '0;

    // DUT outputs.
    logic [NP-1:0]     put_ack;
    logic              det_valid;
    logic [7:0]        det_cor;
    logic [1:0]        det_len;
    logic [1:0]        det_owner;
    logic [255:0]      bomb_map;
    logic [3*NP-1:0]   live_cnt;

    // Scoreboard state.
    int                n_checks = 0;
    int                n_err    = 0;
    int                det_cnt  = 0;
    int                det_snap = 0;
    logic [11:0]       exp_q[$];
    logic [11:0]       exp_e;
    logic [255:0]      exp_map;

    bomb_slot_engine #(
        .NUM_PLAYERS (NP),
        .SLOTS       (SL),
        .FUSE_TICKS  (FT),
        .FUSE_W      (FW)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .tick      (tick),
        .put       (put),
        .cor       (cor),
        .cap       (cap),
        .len       (len),
        .flame     (flame),
        .put_ack   (put_ack),
        .det_valid (det_valid),
        .det_cor   (det_cor),
        .det_len   (det_len),
        .det_owner (det_owner),
        .bomb_map  (bomb_map),
        .live_cnt  (live_cnt)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Count every detonation pulse, sampled mid-cycle.
    always @(negedge CLOCK_50) begin
        if (det_valid) det_cnt++;
    end

    // Stop the run if it stalls, printing a FAIL line first.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [255:0] tile(input logic [7:0] c);
        logic [255:0] m;
        m    = '0;
        m[c] = 1'b1;
        return m;
    endfunction

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".put_ack"},   256'(put_ack),   256'd0);
        chk({tag, ".det_valid"}, 256'(det_valid), 256'd0);
        chk({tag, ".det_cor"},   256'(det_cor),   256'd0);
        chk({tag, ".det_len"},   256'(det_len),   256'd0);
        chk({tag, ".det_owner"}, 256'(det_owner), 256'd0);
        chk({tag, ".bomb_map"},  bomb_map,        256'd0);
        chk({tag, ".live_cnt"},  256'(live_cnt),  256'd0);
    endtask

    task automatic do_put(input logic [NP-1:0] p, input logic [7:0] c0, input logic [7:0] c1);
        put = p;
        cor = {c1, c0};
        step();
        put = '0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    initial begin
        // ---------------- reset ----------------
        cap = {3'd7, 3'd1};
        len = {2'd3, 2'd2};
        step();
        step();
        chk_idle_outputs("reset_held");
        reset = 1'b0;
        step();
        chk_idle_outputs("reset_released");

        // ---------------- 1: single placement ----------------
        do_put(2'b01, 8'h11, 8'h00);
        chk("t1.put_ack",  256'(put_ack),  256'(2'b01));
        chk("t1.bomb_map", bomb_map,       tile(8'h11));
        chk("t1.live_cnt", 256'(live_cnt), 256'(6'b000_001));
        step();
        chk("t1.ack_pulse", 256'(put_ack), 256'd0);

        // ---------------- 2: cap reached, then fuse expiry ----------------
        do_put(2'b01, 8'h12, 8'h00);
        chk("t2.cap_reject", 256'(put_ack),  256'd0);
        chk("t2.map_kept",   bomb_map,       tile(8'h11));
        chk("t2.cnt_kept",   256'(live_cnt), 256'(6'b000_001));
        det_snap = det_cnt;
        repeat (FT - 1) do_tick();
        chk("t2.no_early_det", 256'(det_cnt), 256'(det_snap));
        chk("t2.still_live",   bomb_map,      tile(8'h11));
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("t2.det_lat0", 256'(det_valid), 256'd0);
        step();
        chk("t2.det_lat1", 256'(det_valid), 256'd0);
        step();
        chk("t2.det_valid", 256'(det_valid), 256'd1);
        chk("t2.det_cor",   256'(det_cor),   256'(8'h11));
        chk("t2.det_owner", 256'(det_owner), 256'd0);
        chk("t2.det_len",   256'(det_len),   256'd2);
        chk("t2.map_clear", bomb_map,        256'd0);
        chk("t2.cnt_clear", 256'(live_cnt),  256'd0);
        step();
        chk("t2.det_pulse", 256'(det_valid), 256'd0);
        step();
        chk("t2.det_once",  256'(det_cnt),   256'(det_snap + 1));

        // ---------------- 3: same tile from both players ----------------
        do_put(2'b11, 8'h33, 8'h33);
        chk("t3.put_ack",  256'(put_ack),       256'(2'b01));
        chk("t3.p1_cnt",   256'(live_cnt[5:3]), 256'd0);
        chk("t3.p0_cnt",   256'(live_cnt[2:0]), 256'd1);
        chk("t3.bomb_map", bomb_map,            tile(8'h33));
        flame = tile(8'h33);
        step();
        flame = '0;
        step();
        step();
        chk("t3.flush_valid", 256'(det_valid), 256'd1);
        chk("t3.flush_cor",   256'(det_cor),   256'(8'h33));
        step();

        // ---------------- 4: chain trigger on one of two bombs ----------------
        cap = {3'd7, 3'd7};
        do_put(2'b11, 8'h20, 8'h21);
        chk("t4.put_ack",  256'(put_ack),  256'(2'b11));
        chk("t4.live_cnt", 256'(live_cnt), 256'(6'b001_001));
        repeat (4) do_tick();
        tick  = 1'b1;
        flame = tile(8'h21);
        step();
        tick  = 1'b0;
        flame = '0;
        step();
        step();
        chk("t4.det_valid", 256'(det_valid), 256'd1);
        chk("t4.det_cor",   256'(det_cor),   256'(8'h21));
        chk("t4.det_owner", 256'(det_owner), 256'd1);
        chk("t4.det_len",   256'(det_len),   256'd3);
        chk("t4.bomb_map",  bomb_map,        tile(8'h20));
        chk("t4.live_cnt",  256'(live_cnt),  256'(6'b000_001));
        step();
        // 0x20 has seen 5 ticks. It must detonate on exactly its 90th tick.
        det_snap = det_cnt;
        repeat (FT - 6) do_tick();
        chk("t4.fuse_hold", 256'(det_cnt), 256'(det_snap));
        chk("t4.map_hold",  bomb_map,      tile(8'h20));
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
        chk("t4.late_valid", 256'(det_valid), 256'd1);
        chk("t4.late_cor",   256'(det_cor),   256'(8'h20));
        chk("t4.late_owner", 256'(det_owner), 256'd0);
        step();
        chk("t4.map_empty", bomb_map,       256'd0);
        chk("t4.cnt_empty", 256'(live_cnt), 256'd0);

        // ---------------- 5: fill every slot, drain in slot order ----------------
        exp_map = '0;
        for (int i = 0; i < SL / 2; i++) begin
            do_put(2'b11, 8'h40 + 8'(i), 8'h50 + 8'(i));
            chk("t5.fill_ack", 256'(put_ack), 256'(2'b11));
            exp_map = exp_map | tile(8'h40 + 8'(i)) | tile(8'h50 + 8'(i));
            exp_q.push_back({2'd0, 2'd2, 8'h40 + 8'(i)});
            exp_q.push_back({2'd1, 2'd3, 8'h50 + 8'(i)});
        end
        chk("t5.full_map", bomb_map,       exp_map);
        chk("t5.full_cnt", 256'(live_cnt), 256'(6'b100_100));
        do_put(2'b01, 8'h60, 8'h00);
        chk("t5.no_slot", 256'(put_ack), 256'd0);
        flame = '1;
        step();
        flame = '0;
        step();
        for (int k = 0; k < SL; k++) begin
            step();
            exp_e = exp_q.pop_front();
            chk("t5.drain_valid", 256'(det_valid), 256'd1);
            chk("t5.drain_event", 256'({det_owner, det_len, det_cor}), 256'(exp_e));
        end
        step();
        chk("t5.drain_end", 256'(det_valid), 256'd0);
        chk("t5.map_empty", bomb_map,        256'd0);
        chk("t5.cnt_empty", 256'(live_cnt),  256'd0);

        // ---------------- 6: reset with live and pending bombs ----------------
        do_put(2'b11, 8'h70, 8'h71);
        do_put(2'b01, 8'h72, 8'h00);
        chk("t6.live_cnt", 256'(live_cnt), 256'(6'b001_010));
        flame = tile(8'h70);
        step();
        flame = '0;
        det_snap = det_cnt;
        #2;
        reset = 1'b1;
        #1;
        chk_idle_outputs("t6.in_reset");
        step();
        reset = 1'b0;
        repeat (5) step();
        chk("t6.no_det", 256'(det_cnt), 256'(det_snap));
        chk_idle_outputs("t6.after_reset");

        // Slots are usable again. After that, lowering the cap keeps the
        // existing bomb but blocks new ones.
        do_put(2'b01, 8'h70, 8'h00);
        chk("t6.reuse_ack", 256'(put_ack), 256'(2'b01));
        cap = {3'd7, 3'd0};
        do_put(2'b01, 8'h80, 8'h00);
        chk("t6.cap_low_ack", 256'(put_ack),  256'd0);
        chk("t6.cap_low_cnt", 256'(live_cnt), 256'(6'b000_001));
        chk("t6.cap_low_map", bomb_map,       tile(8'h70));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
